rw_sequencer: RTL and testbench
===============================

RW_SEQUENCER -- requirements
Module: rw_sequencer

Interface
REQ-001 Parameter NUM_TXN, default 5, sets the number of write and the number of read transactions per run.
REQ-002 Parameter CNT_W, default 3, sets the counter width; CNT_W SHALL be at least $clog2(NUM_TXN+1).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its posedge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: begins a run when sampled high in IDLE.
REQ-006 Port wr_req, input, 1 bit: the write requester wants the port.
REQ-007 Port rd_req, input, 1 bit: the read requester wants the port.
REQ-008 Port wr, output, 1 bit: write strobe, high exactly 1 cycle per write.
REQ-009 Port rd, output, 1 bit: read strobe, high exactly 2 consecutive cycles per read.
REQ-010 Port wr_cnt, output, CNT_W bits: writes completed in the current run.
REQ-011 Port rd_cnt, output, CNT_W bits: reads completed in the current run.
REQ-012 Port busy, output, 1 bit: high in every state except IDLE.
REQ-013 Port done, output, 1 bit: one-cycle pulse when a run completes.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, ARB, WR, RD1, RD2, GAP, FIN; all outputs SHALL be Moore decodes of registered state and counters.
REQ-015 In IDLE, start=1 SHALL go to ARB and clear wr_cnt and rd_cnt to 0; start=0 SHALL stay in IDLE.
REQ-016 start SHALL be ignored in every state except IDLE; counters SHALL NOT clear.
REQ-017 In ARB, the write side is eligible when wr_req=1 and wr_cnt<NUM_TXN; the read side is eligible when rd_req=1 and rd_cnt<NUM_TXN.
REQ-018 In ARB, when wr_cnt==NUM_TXN and rd_cnt==NUM_TXN, the next state SHALL be FIN, with request inputs ignored.
REQ-019 In ARB, with only one side eligible, that side SHALL be granted: write goes to WR, read goes to RD1.
REQ-020 In ARB, with both sides eligible, the side not granted last SHALL win (round-robin); a 1-bit last-grant pointer updates on every grant.
REQ-021 In ARB, with no side eligible and the run incomplete, the FSM SHALL stay in ARB with busy=1.
REQ-022 Requests SHALL be sampled only in ARB; request changes in other states have no effect.
REQ-023 WR: wr=1 for 1 cycle, wr_cnt increments on exit, next state GAP.
REQ-024 RD1 then RD2: rd=1 in both, rd_cnt increments on exit from RD2, next state GAP.
REQ-025 GAP: wr=rd=0 for 1 cycle, next state ARB; every strobe is followed by at least 2 low cycles (GAP plus ARB).
REQ-026 FIN: done=1 for 1 cycle, next state IDLE; counters hold their final values until the next start.
REQ-027 wr and rd SHALL never be high in the same cycle; counters SHALL never exceed NUM_TXN.
REQ-028 Latency: with start high at edge k and wr_req=1, wr SHALL be high in cycle k+2; grant to strobe is 1 cycle.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force: state IDLE, wr=rd=busy=done=0, wr_cnt=rd_cnt=0, and the pointer set to write-first.
REQ-030 Reset mid-transaction (e.g. in RD1) SHALL abort the run with no done pulse; a new start is then required.

Verification
REQ-031 Bench SHALL cover: rst; start with wr_req=rd_req=1 held -> order W,R,W,R,W,R,W,R,W,R (write first); done high 1 cycle after wr_cnt=rd_cnt=5, then busy=0.
REQ-032 Bench SHALL cover: only wr_req=1 -> 5 wr pulses spaced 3 cycles, then held in ARB with busy=1 and wr_cnt=5; later rd_req=1 -> 5 reads, then done.
REQ-033 Bench SHALL cover: every rose(rd) -> rd high exactly 2 cycles followed by rd=0; every wr pulse is exactly 1 cycle wide.
REQ-034 Bench SHALL cover: rst pulsed during RD1 -> rd=0 at once, counters 0, no done pulse; a restart completes 5+5 normally.
REQ-035 Bench SHALL cover: start pulsed mid-run -> counters unaffected, exactly one done pulse per run.
REQ-036 Bench SHALL cover: NUM_TXN=1 -> one W, one R, then done; wr and rd never high together across all runs.

Source files
------------

// File: rtl/rw_sequencer.sv
// Arbitrates a shared port between a write and a read requester: NUM_TXN of each per run,
// round-robin when both are eligible, 1-cycle write strobe, 2-cycle read strobe, GAP after each.
module rw_sequencer #(
    parameter int NUM_TXN = 5,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             wr_req,
    input  logic             rd_req,
    output logic             wr,
    output logic             rd,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ARB  = 3'd1;
    localparam logic [2:0] WR   = 3'd2;
    localparam logic [2:0] RD1  = 3'd3;
    localparam logic [2:0] RD2  = 3'd4;
    localparam logic [2:0] GAP  = 3'd5;
    localparam logic [2:0] FIN  = 3'd6;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_TXN);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       last_rd;     // 1: read was granted last, so write wins a tie
    logic       wr_ok;
    logic       rd_ok;
    logic       all_done;
    logic       grant_wr;
    logic       grant_rd;

    always_comb begin
        wr_ok    = wr_req && (wr_cnt < MAX_CNT);
        rd_ok    = rd_req && (rd_cnt < MAX_CNT);
        all_done = (wr_cnt == MAX_CNT) && (rd_cnt == MAX_CNT);
        grant_wr = !all_done && wr_ok && (!rd_ok || last_rd);
        grant_rd = !all_done && rd_ok && !grant_wr;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = ARB;
            ARB: begin
                if (all_done)      state_nxt = FIN;
                else if (grant_wr) state_nxt = WR;
                else if (grant_rd) state_nxt = RD1;
            end
            WR:      state_nxt = GAP;
            RD1:     state_nxt = RD2;
            RD2:     state_nxt = GAP;
            GAP:     state_nxt = ARB;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            last_rd <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                wr_cnt <= '0;
                rd_cnt <= '0;
            end
            // Counts advance as the strobe phase is left, so they reflect completed transfers.
            if (state == WR)  wr_cnt <= wr_cnt + CNT_W'(1);
            if (state == RD2) rd_cnt <= rd_cnt + CNT_W'(1);
            if (grant_wr && state == ARB)      last_rd <= 1'b0;
            else if (grant_rd && state == ARB) last_rd <= 1'b1;
        end
    end

    assign wr   = (state == WR);
    assign rd   = (state == RD1) || (state == RD2);
    assign busy = (state != IDLE);
    assign done = (state == FIN);

endmodule

// File: tb/tb_rw_sequencer.sv
// Drives two sequencers (5 and 1 transactions per run) from shared inputs and checks every
// cycle against a transaction-level model of grants, strobe lengths and completion counts.
module tb_rw_sequencer;

    logic clk = 1'b0;
    logic rst, start, wr_req, rd_req;
    logic wr0, rd0, busy0, done0;
    logic [2:0] wc0, rc0;
    logic wr1, rd1, busy1, done1;
    logic [0:0] wc1, rc1;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: a run is either arbitrating (kind NONE) or playing out one granted item,
    // where age counts cycles since the grant.
    localparam int K_NONE = 0;
    localparam int K_W    = 1;
    localparam int K_R    = 2;
    localparam int K_FIN  = 3;

    int    nmax  [2];
    int    act   [2];
    int    mwc   [2];
    int    mrc   [2];
    int    kind  [2];
    int    age   [2];
    int    lrd   [2];
    int    wlen  [2];
    int    rlen  [2];
    int    dones [2];
    string ord;

    always #5 clk = ~clk;

    rw_sequencer #(.NUM_TXN(5), .CNT_W(3)) dut0 (
        .clk(clk), .rst(rst), .start(start), .wr_req(wr_req), .rd_req(rd_req),
        .wr(wr0), .rd(rd0), .wr_cnt(wc0), .rd_cnt(rc0), .busy(busy0), .done(done0)
    );

    rw_sequencer #(.NUM_TXN(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .wr_req(wr_req), .rd_req(rd_req),
        .wr(wr1), .rd(rd1), .wr_cnt(wc1), .rd_cnt(rc1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic w, input logic r, input logic b,
                                         input logic d, input logic [31:0] cw,
                                         input logic [31:0] cr);
        return {12'd0, w, r, b, d, cw[7:0], cr[7:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            act[i]  = 0;
            mwc[i]  = 0;
            mrc[i]  = 0;
            kind[i] = K_NONE;
            age[i]  = 0;
            lrd[i]  = 1;
            wlen[i] = 0;
            rlen[i] = 0;
        end
    endtask

    task automatic model_edge(input int i);
        bit we, re;
        if (act[i] == 0) begin
            if (start) begin
                act[i]  = 1;
                mwc[i]  = 0;
                mrc[i]  = 0;
                kind[i] = K_NONE;
            end
        end else begin
            case (kind[i])
                K_NONE: begin
                    if (mwc[i] == nmax[i] && mrc[i] == nmax[i]) begin
                        kind[i] = K_FIN;
                    end else begin
                        we = wr_req && (mwc[i] < nmax[i]);
                        re = rd_req && (mrc[i] < nmax[i]);
                        if (we && (!re || lrd[i] == 1)) begin
                            kind[i] = K_W; age[i] = 0; lrd[i] = 0;
                        end else if (re) begin
                            kind[i] = K_R; age[i] = 0; lrd[i] = 1;
                        end
                    end
                end
                K_W: begin
                    if (age[i] == 0) begin mwc[i]++; age[i] = 1; end
                    else kind[i] = K_NONE;
                end
                K_R: begin
                    if (age[i] == 0) age[i] = 1;
                    else if (age[i] == 1) begin mrc[i]++; age[i] = 2; end
                    else kind[i] = K_NONE;
                end
                default: begin
                    act[i]  = 0;
                    kind[i] = K_NONE;
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        logic w [2];
        logic r [2];
        logic b [2];
        logic d [2];
        logic [31:0] cw [2];
        logic [31:0] cr [2];
        logic ew, er;
        w[0] = wr0; r[0] = rd0; b[0] = busy0; d[0] = done0; cw[0] = 32'(wc0); cr[0] = 32'(rc0);
        w[1] = wr1; r[1] = rd1; b[1] = busy1; d[1] = done1; cw[1] = 32'(wc1); cr[1] = 32'(rc1);
        for (int i = 0; i < 2; i++) begin
            ew = (act[i] == 1) && (kind[i] == K_W) && (age[i] == 0);
            er = (act[i] == 1) && (kind[i] == K_R) && (age[i] < 2);
            chk($sformatf("dut%0d {wr,rd,busy,done,wr_cnt,rd_cnt}", i),
                pack(w[i], r[i], b[i], d[i], cw[i], cr[i]),
                pack(ew, er, act[i] == 1, kind[i] == K_FIN, mwc[i], mrc[i]));
            chk($sformatf("dut%0d wr_rd_exclusive", i), 32'(w[i] & r[i]), 32'd0);
            if (w[i] === 1'b1) begin
                wlen[i]++;
                if (i == 0 && wlen[i] == 1) ord = {ord, "W"};
            end else if (wlen[i] > 0) begin
                chk($sformatf("dut%0d wr_width", i), 32'(wlen[i]), 32'd1);
                wlen[i] = 0;
            end
            if (r[i] === 1'b1) begin
                rlen[i]++;
                if (i == 0 && rlen[i] == 1) ord = {ord, "R"};
            end else if (rlen[i] > 0) begin
                chk($sformatf("dut%0d rd_width", i), 32'(rlen[i]), 32'd2);
                rlen[i] = 0;
            end
            if (d[i] === 1'b1) dones[i]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else for (int i = 0; i < 2; i++) model_edge(i);
        #1;
        check_outputs();
    endtask

    task automatic run_to_idle(input int max_cycles);
        for (int k = 0; k < max_cycles && (act[0] == 1 || act[1] == 1); k++) step();
        chk("run_finishes_busy0", 32'(busy0), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        nmax[0] = 5;
        nmax[1] = 1;
        rst = 1'b1; start = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        model_reset();
        dones = '{0, 0};
        ord = "";
        #3;
        chk("reset_wr", 32'(wr0), 32'd0);
        chk("reset_rd", 32'(rd0), 32'd0);
        chk("reset_busy", 32'(busy0), 32'd0);
        chk("reset_done", 32'(done0), 32'd0);
        chk("reset_wr_cnt", 32'(wc0), 32'd0);
        chk("reset_rd_cnt", 32'(rc0), 32'd0);
        step();
        step();
        rst = 1'b0;

        // Both requesters held: strict alternation, write first after reset.
        wr_req = 1'b1; rd_req = 1'b1;
        pulse_start();
        run_to_idle(200);
        n_chk++;
        assert (ord == "WRWRWRWRWR") else begin
            n_fail++;
            $error("FAIL grant_order: got %s expected WRWRWRWRWR", ord);
        end
        chk("run1_done_pulses", 32'(dones[0]), 32'd1);
        chk("run1_final_wr_cnt", 32'(wc0), 32'd5);

        // Writes only: stalls in arbitration after 5 writes until reads appear.
        dones = '{0, 0};
        wr_req = 1'b1; rd_req = 1'b0;
        pulse_start();
        repeat (40) step();
        chk("wr_only_wr_cnt", 32'(wc0), 32'd5);
        chk("wr_only_rd_cnt", 32'(rc0), 32'd0);
        chk("wr_only_busy", 32'(busy0), 32'd1);
        chk("wr_only_no_done", 32'(dones[0]), 32'd0);
        rd_req = 1'b1;
        run_to_idle(200);
        chk("run2_rd_cnt", 32'(rc0), 32'd5);
        chk("run2_done_pulses", 32'(dones[0]), 32'd1);

        // Reset during the first read cycle aborts the run.
        wr_req = 1'b1; rd_req = 1'b1;
        pulse_start();
        for (int k = 0; k < 50 && rd0 !== 1'b1; k++) step();
        chk("reached_rd1", 32'(rd0), 32'd1);
        dones = '{0, 0};
        rst = 1'b1;
        #1;
        chk("abort_rd", 32'(rd0), 32'd0);
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_wr_cnt", 32'(wc0), 32'd0);
        chk("abort_rd_cnt", 32'(rc0), 32'd0);
        step();
        rst = 1'b0;
        repeat (10) step();
        chk("abort_no_done", 32'(dones[0]), 32'd0);
        pulse_start();
        run_to_idle(200);
        chk("restart_done_pulses", 32'(dones[0]), 32'd1);
        chk("restart_rd_cnt", 32'(rc0), 32'd5);

        // start re-asserted mid-run is ignored.
        dones = '{0, 0};
        pulse_start();
        repeat (7) step();
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        repeat (5) step();
        pulse_start();
        run_to_idle(200);
        chk("midstart_done_pulses", 32'(dones[0]), 32'd1);
        chk("midstart_wr_cnt", 32'(wc0), 32'd5);
        chk("midstart_rd_cnt", 32'(rc0), 32'd5);

        // Random requests, starts and occasional resets.
        for (int c = 0; c < 800; c++) begin
            wr_req = ($urandom_range(0, 3) != 0);
            rd_req = ($urandom_range(0, 3) != 0);
            start  = ($urandom_range(0, 15) == 0);
            rst    = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        start = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
